matrix_mac_sequencer: RTL and testbench

Sequential 2x2 fixed-point matrix multiplier for the filter datapath. It computes R = A·B using one shared multiplier and one accumulator, stepping through the eight partial products in a fixed order. It trades the eight parallel multipliers of the combinational 2x2 product for an 8-cycle latency. Inputs are accepted through a valid/ready handshake, and results are held under output backpressure.

---
 rtl/matseq_pkg.sv | 21 ++
 rtl/matseq_mac.sv | 66 ++++++
 rtl/matrix_mac_sequencer.sv | 112 +++++++++++
 tb/tb_matrix_mac_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/matseq_pkg.sv
// Shared types and constants for the sequential 2x2 matrix MAC.
// Optional macro MATSEQ_SAT_EN selects saturating arithmetic (see matseq_mac).
package matseq_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int NUM_STEPS = 8;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_FRAC  = 8;

  // Largest positive value representable in a w-bit signed word
  function automatic logic signed [63:0] sat_hi(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  // Most negative value representable in a w-bit signed word
  function automatic logic signed [63:0] sat_lo(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/matseq_mac.sv
// Shared multiplier plus accumulator for matrix_mac_sequencer.
// Product is floor(x*y / 2^FRAC). Define MATSEQ_SAT_EN to clamp the product
// and the odd-step sum to the WIDTH-bit signed range instead of wrapping.
module matseq_mac
  import matseq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  input  logic             i_clr,
  input  logic             i_load,
  output logic [WIDTH-1:0] o_sum
);

  logic signed [2*WIDTH-1:0] w_full;
  logic        [WIDTH-1:0]   w_prod;
  logic        [WIDTH-1:0]   r_acc;

  assign w_full = $signed(i_x) * $signed(i_y);

`ifdef MATSEQ_SAT_EN
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(sat_hi(WIDTH));
  localparam logic [WIDTH-1:0] MINV = WIDTH'(sat_lo(WIDTH));

  logic signed [2*WIDTH-1:0] w_shift;
  logic signed [63:0]        w_sh64;
  logic        [WIDTH:0]     w_wide;

  assign w_shift = w_full >>> FRAC;
  assign w_sh64  = 64'(w_shift);

  // Clamp the shifted product into the result range
  always_comb begin
    w_prod = w_shift[WIDTH-1:0];
    if (w_sh64 > sat_hi(WIDTH))      w_prod = MAXV;
    else if (w_sh64 < sat_lo(WIDTH)) w_prod = MINV;
  end

  assign w_wide = {r_acc[WIDTH-1], r_acc} + {w_prod[WIDTH-1], w_prod};

  // Sum in WIDTH+1 bits; a disagreeing top pair of bits means overflow
  always_comb begin
    o_sum = w_wide[WIDTH-1:0];
    if (w_wide[WIDTH] != w_wide[WIDTH-1]) o_sum = w_wide[WIDTH] ? MINV : MAXV;
  end
`else
  logic w_unused;

  // Arithmetic shift then truncate is the same as picking the middle bits
  assign w_prod   = w_full[FRAC +: WIDTH];
  assign w_unused = ^{w_full[FRAC-1:0], w_full[2*WIDTH-1:FRAC+WIDTH]};
  assign o_sum    = r_acc + w_prod;
`endif

  // Accumulator: cleared on accept, loaded with the product on even steps
  always_ff @(posedge clk) begin
    if (!rst_n)      r_acc <= '0;
    else if (i_clr)  r_acc <= '0;
    else if (i_load) r_acc <= w_prod;
  end

endmodule

// File: rtl/matrix_mac_sequencer.sv
// Sequential 2x2 fixed-point matrix multiply R = A*B using one MAC, 8 steps.
// Optional macro MATSEQ_SAT_EN: saturating product and sum (default: wrap).
module matrix_mac_sequencer
  import matseq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] f,
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] h,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r00,
  output logic [WIDTH-1:0] r01,
  output logic [WIDTH-1:0] r10,
  output logic [WIDTH-1:0] r11,
  output logic             busy
);

  state_t                  r_state, w_next;
  logic [2:0]              r_step;
  logic [3:0][WIDTH-1:0]   r_ma;   // a, b, c, d
  logic [3:0][WIDTH-1:0]   r_mb;   // e, f, g, h
  logic [3:0][WIDTH-1:0]   r_res;  // r00, r01, r10, r11
  logic                    w_accept;
  logic                    w_run;
  logic [WIDTH-1:0]        w_x, w_y, w_sum;

  assign w_run = (r_state == RUN);

  // step[2] picks the A row, step[1] the B column, step[0] the inner index
  assign w_x = r_ma[{r_step[2], r_step[0]}];
  assign w_y = r_mb[{r_step[0], r_step[1]}];

  // Next-state and handshake outputs
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    w_accept  = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = RUN;
        end
      end
      RUN:  if (r_step == 3'(NUM_STEPS - 1)) w_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign busy = (r_state != IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Step counter and operand capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_step <= '0;
      r_ma   <= '0;
      r_mb   <= '0;
    end else if (w_accept) begin
      r_step <= '0;
      r_ma   <= {d, c, b, a};
      r_mb   <= {h, g, f, e};
    end else if (w_run) begin
      r_step <= r_step + 3'd1;
    end
  end

  // Odd steps finish one result element
  always_ff @(posedge clk) begin
    if (!rst_n)                r_res <= '0;
    else if (w_run && r_step[0]) r_res[r_step[2:1]] <= w_sum;
  end

  matseq_mac #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_x    (w_x),
    .i_y    (w_y),
    .i_clr  (w_accept),
    .i_load (w_run && !r_step[0]),
    .o_sum  (w_sum)
  );

  assign r00 = r_res[0];
  assign r01 = r_res[1];
  assign r10 = r_res[2];
  assign r11 = r_res[3];

endmodule

// File: tb/tb_matrix_mac_sequencer.sv
// Directed bench for matrix_mac_sequencer (8.8 defaults).
module tb_matrix_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0, b = '0, c = '0, d = '0;
  logic [15:0] e = '0, f = '0, g = '0, h = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] r00, r01, r10, r11;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  matrix_mac_sequencer #(.WIDTH(16), .FRAC(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .out_valid(out_valid), .out_ready(out_ready),
    .r00(r00), .r01(r01), .r10(r10), .r11(r11), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic [15:0] va, vb, vc, vd, ve, vf, vg, vh);
    a = va; b = vb; c = vc; d = vd;
    e = ve; f = vf; g = vg; h = vh;
  endtask

  // Accept one matrix pair and count edges until out_valid (bounded)
  task automatic run_mat(input logic [15:0] va, vb, vc, vd, ve, vf, vg, vh,
                         output int lat);
    set_ops(va, vb, vc, vd, ve, vf, vg, vh);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    set_ops('0, '0, '0, '0, '0, '0, '0, '0);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      lat++;
      if (out_valid) break;
    end
  endtask

  task automatic release_result;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick; tick;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if ({r00, r01, r10, r11} !== 64'h0) begin n_bad++; $display("FAIL reset_results: got %h want 0", {r00, r01, r10, r11}); end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_identity;
    int lat;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL ident_ready_before: got %b want 1", in_ready); end
    run_mat(16'h0100, 16'h0000, 16'h0000, 16'h0100,
            16'h0200, 16'h0080, 16'hFF00, 16'h0300, lat);
    n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL ident_latency: got %0d want 8", lat); end
    n_cmp++; if ({r00, r01, r10, r11} !== 64'h0200_0080_FF00_0300) begin n_bad++; $display("FAIL ident_result: got %h want 0200008 0FF000300", {r00, r01, r10, r11}); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ident_busy_done: got %b want 1", busy); end
    release_result;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL ident_complete: got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready); end
  endtask

  task automatic test_mixed;
    int lat;
    run_mat(16'h0200, 16'h0100, 16'h0000, 16'h0000,
            16'h0180, 16'h0000, 16'h0040, 16'h0000, lat);
    n_cmp++; if ({r00, r01, r10, r11} !== 64'h0340_0000_0000_0000) begin n_bad++; $display("FAIL mixed_result: got %h want 0340000000000000", {r00, r01, r10, r11}); end
    release_result;
  endtask

  task automatic test_floor;
    int lat;
    run_mat(16'hFFFF, 16'h0000, 16'h0000, 16'h0000,
            16'h0080, 16'h0000, 16'h0000, 16'h0000, lat);
    n_cmp++; if (r00 !== 16'hFFFF) begin n_bad++; $display("FAIL floor_r00: got %h want ffff", r00); end
    release_result;
  endtask

  task automatic test_overflow;
    int lat;
    logic [15:0] exp;
`ifdef MATSEQ_SAT_EN
    exp = 16'h7FFF;
`else
    exp = 16'hFE00;
`endif
    run_mat(16'h7F00, 16'h7F00, 16'h0000, 16'h0000,
            16'h0100, 16'h0000, 16'h0100, 16'h0000, lat);
    n_cmp++; if (r00 !== exp) begin n_bad++; $display("FAIL overflow_r00: got %h want %h", r00, exp); end
    release_result;
  endtask

  task automatic test_backpressure;
    int lat;
    run_mat(16'h0200, 16'h0100, 16'h0000, 16'h0000,
            16'h0180, 16'h0000, 16'h0040, 16'h0000, lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      set_ops(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
              16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      tick;
      n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || r00 !== 16'h0340 || r01 !== 16'h0000)
        begin n_bad++; $display("FAIL bp_hold[%0d]: got ov=%b ir=%b r00=%h r01=%h want ov=1 ir=0 r00=0340 r01=0000", i, out_valid, in_ready, r00, r01); end
    end
    in_valid = 1'b0;
    release_result;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL bp_release: got ir=%b ov=%b busy=%b want 1 0 0", in_ready, out_valid, busy); end
    n_cmp++; if (r00 !== 16'h0340) begin n_bad++; $display("FAIL bp_retained: got %h want 0340", r00); end
  endtask

  task automatic test_reset_mid;
    int lat;
    set_ops(16'h0100, 16'h0000, 16'h0000, 16'h0100,
            16'h0200, 16'h0080, 16'hFF00, 16'h0300);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (4) tick;
    rst_n = 1'b0;
    tick;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL midrst_ctrl: got ir=%b ov=%b busy=%b want 1 0 0", in_ready, out_valid, busy); end
    n_cmp++; if ({r00, r01, r10, r11} !== 64'h0) begin n_bad++; $display("FAIL midrst_results: got %h want 0", {r00, r01, r10, r11}); end
    rst_n = 1'b1;
    run_mat(16'h0200, 16'h0100, 16'h0000, 16'h0000,
            16'h0180, 16'h0000, 16'h0040, 16'h0000, lat);
    n_cmp++; if (lat !== 8 || {r00, r01, r10, r11} !== 64'h0340_0000_0000_0000) begin n_bad++; $display("FAIL midrst_rerun: got lat=%0d r=%h want lat=8 r=0340000000000000", lat, {r00, r01, r10, r11}); end
    release_result;
  endtask

  task automatic test_back_to_back;
    int acc_cyc[$];
    set_ops(16'hFFFF, 16'h0000, 16'h0000, 16'h0000,
            16'h0080, 16'h0000, 16'h0000, 16'h0000);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (in_ready && in_valid) acc_cyc.push_back(cyc);
      tick;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_cmp++;
    if (acc_cyc.size() < 2) begin
      n_bad++; $display("FAIL b2b_accepts: got %0d accepts want >= 2", acc_cyc.size());
    end else if (acc_cyc[1] - acc_cyc[0] !== 10) begin
      n_bad++; $display("FAIL b2b_period: got %0d want 10", acc_cyc[1] - acc_cyc[0]);
    end
    n_cmp++; if (r00 !== 16'hFFFF) begin n_bad++; $display("FAIL b2b_r00: got %h want ffff", r00); end
    repeat (12) tick;
  endtask

  initial begin
    test_reset;
    test_identity;
    test_mixed;
    test_floor;
    test_overflow;
    test_backpressure;
    test_reset_mid;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
